tdm_sequencer: RTL and testbench

//   Parametrised time-division sequencer: cycles through NUM_CH source channels,

---
 rtl/tdm_sequencer.sv | 145 ++++++++++++++
 tb/tb_tdm_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_sequencer.sv
// tdm_sequencer: time-division sequencer cycling NUM_CH channels with
// programmable per-channel slot counts, muxing the owner's word to data_out.
// Ports: sysclk, rst_n (async low), run (sync clear when 0), ch_en,
//   seg_len, ch_data -> data_out, data_valid, ch_sel, seg_count,
//   bit_count, seg_start, frame_start (all registered).
module tdm_sequencer #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W = 8,
  parameter int BIT_W = 3,
  parameter bit SKIP_DISABLED = 1'b0,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*CNT_W-1:0]  seg_len,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic [CH_W-1:0]          ch_sel,
  output logic [CNT_W-1:0]         seg_count,
  output logic [BIT_W-1:0]         bit_count,
  output logic                     seg_start,
  output logic                     frame_start
);

  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              act_q, act_d;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [BIT_W-1:0]  bcnt_q, bcnt_d;
  logic              ss_q, ss_d;
  logic              fs_q, fs_d;

  logic [CH_W-1:0]   first_ch;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   nxt_ch;
  logic [CNT_W-1:0]  len;
  logic              last;

  always_comb begin
    first_ch = '0;
    if (SKIP_DISABLED) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (ch_en[i]) first_ch = CH_W'(i);
      end
    end
  end

  // First run cycle after idle starts from the frame head, which in
  // skip mode is the lowest enabled channel rather than the cleared 0.
  assign cur_ch = act_q ? ch_q : first_ch;
  assign len = seg_len[int'(cur_ch)*CNT_W +: CNT_W];
  // len==0 acts as 1; >= also ends a segment whose length shrank.
  assign last = (len == '0) || (cnt_q >= len - CNT_W'(1));

  always_comb begin
    nxt_ch = cur_ch;
    if (SKIP_DISABLED) begin
      // Descending scan so the nearest enabled successor wins.
      for (int i = NUM_CH; i >= 1; i--) begin
        if (ch_en[(int'(cur_ch) + i) % NUM_CH]) begin
          nxt_ch = CH_W'((int'(cur_ch) + i) % NUM_CH);
        end
      end
    end else if (cur_ch == CH_W'(NUM_CH - 1)) begin
      nxt_ch = '0;
    end else begin
      nxt_ch = cur_ch + 1'b1;
    end
  end

  always_comb begin
    ch_d   = '0;
    cnt_d  = '0;
    bit_d  = '0;
    act_d  = 1'b0;
    dout_d = '0;
    dv_d   = 1'b0;
    sel_d  = '0;
    scnt_d = '0;
    bcnt_d = '0;
    ss_d   = 1'b0;
    fs_d   = 1'b0;
    if (run) begin
      act_d  = 1'b1;
      ch_d   = last ? nxt_ch : cur_ch;
      cnt_d  = last ? '0 : cnt_q + 1'b1;
      bit_d  = bit_q + 1'b1;
      dv_d   = ch_en[cur_ch];
      if (ch_en[cur_ch]) begin
        dout_d = ch_data[int'(cur_ch)*DATA_W +: DATA_W];
      end
      sel_d  = cur_ch;
      scnt_d = cnt_q;
      bcnt_d = bit_q;
      ss_d   = (cnt_q == '0);
      fs_d   = (cnt_q == '0) && (cur_ch == first_ch);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      act_q  <= 1'b0;
      dout_q <= '0;
      dv_q   <= 1'b0;
      sel_q  <= '0;
      scnt_q <= '0;
      bcnt_q <= '0;
      ss_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      act_q  <= act_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      sel_q  <= sel_d;
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
      ss_q   <= ss_d;
      fs_q   <= fs_d;
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign ch_sel      = sel_q;
  assign seg_count   = scnt_q;
  assign bit_count   = bcnt_q;
  assign seg_start   = ss_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tdm_sequencer.sv
// tb_tdm_sequencer: scoreboard bench for tdm_sequencer, one instance
// per SKIP_DISABLED setting driven by shared stimulus.
module tb_tdm_sequencer;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic [2:0] b;
    logic       ss;
    logic       fs;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [3:0]  ch_en;
  logic [31:0] seg_len;
  logic [31:0] ch_data;

  logic [7:0] d0, d1, sc0, sc1;
  logic       v0, v1, ss0, ss1, fs0, fs1;
  logic [1:0] c0w, c1w;
  logic [2:0] b0, b1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   L[4];
  logic [7:0] D[4];
  exp_t q0[$];
  exp_t q1[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;

  tdm_sequencer #(.SKIP_DISABLED(1'b0)) u0 (
    .sysclk(sysclk), .rst_n(rst_n), .run(run),
    .ch_en(ch_en), .seg_len(seg_len), .ch_data(ch_data),
    .data_out(d0), .data_valid(v0), .ch_sel(c0w),
    .seg_count(sc0), .bit_count(b0),
    .seg_start(ss0), .frame_start(fs0)
  );

  tdm_sequencer #(.SKIP_DISABLED(1'b1)) u1 (
    .sysclk(sysclk), .rst_n(rst_n), .run(run),
    .ch_en(ch_en), .seg_len(seg_len), .ch_data(ch_data),
    .data_out(d1), .data_valid(v1), .ch_sel(c1w),
    .seg_count(sc1), .bit_count(b1),
    .seg_start(ss1), .frame_start(fs1)
  );

  function automatic obs_t mk(input int ch, input int cnt, input int b,
                              input bit ss, input bit fs,
                              input logic [7:0] dat, input bit v);
    obs_t o;
    o.d = dat; o.v = v; o.ch = 2'(ch); o.cnt = 8'(cnt);
    o.b = 3'(b); o.ss = ss; o.fs = fs;
    return o;
  endfunction

  task automatic push(input int dut, input int c, input obs_t o);
    exp_t e;
    e.cyc = c; e.o = o;
    if (dut == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic push_zero(input int c);
    push(0, c, '0);
    push(1, c, '0);
  endtask

  // Expected slots from a frame start: channels in order, each held for
  // its length (0 counts as 1); skip mode drops disabled channels.
  task automatic push_run(input int dut, input int cs, input int n,
                          input logic [3:0] en, input bit skip);
    int ord[$];
    int k;
    for (int c = 0; c < 4; c++) if (!skip || en[c]) ord.push_back(c);
    k = 0;
    while (k < n && ord.size() > 0) begin
      foreach (ord[x]) begin
        int ch;
        int ln;
        ch = ord[x];
        ln = (L[ch] == 0) ? 1 : L[ch];
        for (int t = 0; t < ln && k < n; t++) begin
          push(dut, cs + 1 + k,
               mk(ch, t, k % 8, t == 0, t == 0 && x == 0,
                  en[ch] ? D[ch] : 8'h00, en[ch]));
          k++;
        end
      end
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      seg_len[i*8 +: 8] = 8'(L[i]);
      ch_data[i*8 +: 8] = D[i];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input int dut, input obs_t a);
    exp_t e;
    int sz;
    sz = (dut == 0) ? q0.size() : q1.size();
    while (sz > 0) begin
      e = (dut == 0) ? q0[0] : q1[0];
      if (e.cyc > cyc) break;
      if (dut == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
      sz--;
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL dut%0d slot cyc %0d missed (now %0d)",
                 dut, e.cyc, cyc);
      end else if (a !== e.o) begin
        errors++;
        $display("FAIL dut%0d cyc %0d: got d=%h v=%b ch=%0d cnt=%0d b=%0d ss=%b fs=%b, expected d=%h v=%b ch=%0d cnt=%0d b=%0d ss=%b fs=%b",
                 dut, cyc, a.d, a.v, a.ch, a.cnt, a.b, a.ss, a.fs,
                 e.o.d, e.o.v, e.o.ch, e.o.cnt, e.o.b, e.o.ss, e.o.fs);
      end
    end
  endtask

  always @(negedge sysclk) begin
    chk(0, {d0, v0, c0w, sc0, b0, ss0, fs0});
    chk(1, {d1, v1, c1w, sc1, b1, ss1, fs1});
  end

  initial begin
    int cs;
    rst_n = 1'b0;
    run = 1'b0;
    ch_en = 4'hF;
    L = '{88, 80, 56, 32};
    D = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    apply();
    tick(2);
    rst_n = 1'b1;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);

    // Full frames, all enabled, 256-cycle frame
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 520, 4'hF, 1'b0);
    push_run(1, cs, 520, 4'hF, 1'b1);
    tick(520);

    // ch1/ch3 enabled: zero slots vs skipped slots
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    ch_en = 4'b1010;
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 300, 4'b1010, 1'b0);
    push_run(1, cs, 300, 4'b1010, 1'b1);
    tick(300);

    // ch0 length 0 then 1: single-slot segment
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    ch_en = 4'hF;
    L[0] = 0;
    apply();
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 200, 4'hF, 1'b0);
    push_run(1, cs, 200, 4'hF, 1'b1);
    tick(200);
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    L[0] = 1;
    apply();
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 20, 4'hF, 1'b0);
    push_run(1, cs, 20, 4'hF, 1'b1);
    tick(20);

    // Shrink ch1 80->10 while its counter is at 40
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    L[0] = 88;
    apply();
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 129, 4'hF, 1'b0);
    push_run(1, cs, 129, 4'hF, 1'b1);
    tick(128);
    seg_len[15:8] = 8'd10;
    for (int u = 0; u < 2; u++) begin
      push(u, cs + 130, mk(2, 0, 1, 1, 0, 8'hC3, 1));
      push(u, cs + 131, mk(2, 1, 2, 0, 0, 8'hC3, 1));
      push(u, cs + 186, mk(3, 0, 1, 1, 0, 8'hD4, 1));
    end
    tick(60);
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    apply();

    // run dropped at cnt 37, then restart at frame head
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 38, 4'hF, 1'b0);
    push_run(1, cs, 38, 4'hF, 1'b1);
    tick(38);
    run = 1'b0;
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    push_zero(cyc + 3);
    tick(3);
    cs = cyc;
    run = 1'b1;
    push_run(0, cs, 99, 4'hF, 1'b0);
    push_run(1, cs, 99, 4'hF, 1'b1);
    tick(100);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    push_zero(cyc);
    push_zero(cyc + 1);
    push_zero(cyc + 2);
    tick(2);
    rst_n = 1'b1;
    cs = cyc;
    push_run(0, cs, 30, 4'hF, 1'b0);
    push_run(1, cs, 30, 4'hF, 1'b1);
    tick(32);

    for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++) begin
      @(posedge sysclk);
    end
    if ((q0.size() + q1.size()) > 0) begin
      $display("FAIL drain: %0d expected slots left, required 0",
               q0.size() + q1.size());
      errors += q0.size() + q1.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
